// File: rtl/pwm_multi.sv
`default_nettype none
// ============================================================================
// Module   : pwm_multi
// Purpose  : Multi-channel PWM generator. One shared prescaler and period
//            counter, a per-channel duty compare, edge- or center-aligned
//            counting, and a double-buffered configuration that only takes
//            effect at a period boundary.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_multi #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int PRE_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      load,
    input  logic [WIDTH-1:0]          period_in,
    input  logic [PRE_W-1:0]          prescale_in,
    input  logic                      mode_in,
    input  logic [CHANNELS*WIDTH-1:0] duty_in,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      period_tick,
    output logic                      load_ack
);

    localparam logic [WIDTH-1:0] c_ONE     = WIDTH'(1);
    localparam logic [PRE_W-1:0] c_PRE_ONE = PRE_W'(1);

    // Shadow set, written by the host side.
    logic [WIDTH-1:0]          r_sh_period;
    logic [PRE_W-1:0]          r_sh_pre;
    logic                      r_sh_mode;
    logic [CHANNELS*WIDTH-1:0] r_sh_duty;
    logic                      r_pending;

    // Active set, used by the counter and comparators.
    logic [WIDTH-1:0]          r_act_period;
    logic [PRE_W-1:0]          r_act_pre;
    logic                      r_act_mode;
    logic [CHANNELS*WIDTH-1:0] r_act_duty;

    // Timebase state.
    logic [PRE_W-1:0]          r_pre_cnt;
    logic [WIDTH-1:0]          r_cnt;
    logic                      r_dir;      // 0 = counting up, 1 = counting down

    logic                      w_tick;
    logic                      w_small;    // P <= 1: center mode degenerates to edge
    logic                      w_center;   // true triangle counting is in effect
    logic                      w_bnd;
    logic                      w_apply;
    logic [CHANNELS-1:0]       w_hit;

    assign w_tick   = en && (r_pre_cnt == r_act_pre);
    assign w_small  = (r_act_period <= c_ONE);
    assign w_center = r_act_mode && !w_small;
    // The boundary is the tick whose next counter value is 0.
    assign w_bnd    = w_tick && (w_center ? (r_dir && (r_cnt == c_ONE))
                                          : (r_cnt == r_act_period));
    assign w_apply  = w_bnd && r_pending;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_cmp
            assign w_hit[gi] = (r_cnt < r_act_duty[gi*WIDTH +: WIDTH]);
        end
    endgenerate

    // Shadow capture on load; shadow-to-active transfer on a pending boundary.
    // A load coinciding with the boundary applies the old shadow and re-arms.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_period  <= '0;
            r_sh_pre     <= '0;
            r_sh_mode    <= 1'b0;
            r_sh_duty    <= '0;
            r_pending    <= 1'b0;
            r_act_period <= '0;
            r_act_pre    <= '0;
            r_act_mode   <= 1'b0;
            r_act_duty   <= '0;
        end else begin
            if (w_apply) begin
                r_act_period <= r_sh_period;
                r_act_pre    <= r_sh_pre;
                r_act_mode   <= r_sh_mode;
                r_act_duty   <= r_sh_duty;
            end
            if (load) begin
                r_sh_period <= period_in;
                r_sh_pre    <= prescale_in;
                r_sh_mode   <= mode_in;
                r_sh_duty   <= duty_in;
                r_pending   <= 1'b1;
            end else if (w_apply) begin
                r_pending   <= 1'b0;
            end
        end
    end

    // Prescaler and period counter; everything holds while disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre_cnt <= '0;
            r_cnt     <= '0;
            r_dir     <= 1'b0;
        end else if (en) begin
            if (w_tick) begin
                r_pre_cnt <= '0;
                if (w_bnd) begin
                    r_cnt <= '0;
                    r_dir <= 1'b0;
                end else if (w_center) begin
                    if (!r_dir) begin
                        if (r_cnt == r_act_period) begin
                            r_cnt <= r_cnt - c_ONE;
                            r_dir <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + c_ONE;
                        end
                    end else begin
                        r_cnt <= r_cnt - c_ONE;
                    end
                end else begin
                    r_cnt <= r_cnt + c_ONE;
                end
            end else begin
                r_pre_cnt <= r_pre_cnt + c_PRE_ONE;
            end
        end
    end

    // Registered outputs: one clock from counter to pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_out     <= '0;
            period_tick <= 1'b0;
            load_ack    <= 1'b0;
        end else begin
            pwm_out     <= en ? w_hit : '0;
            period_tick <= w_bnd;
            load_ack    <= w_apply;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_multi
// Purpose  : Self-checking bench for pwm_multi: table of configurations with
//            hand-computed period/high times, plus directed sequences for
//            double buffering, coincident load, enable and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_multi;

    typedef struct packed {
        logic [7:0]  p;
        logic [7:0]  d;
        logic        mode;
        logic [31:0] duty;     // {ch3, ch2, ch1, ch0}
        logic [15:0] per;      // expected period in clocks
        logic [63:0] hi;       // expected high clocks {ch3, ch2, ch1, ch0}
        logic        at_tick;  // expected pwm_out[1] in the period_tick cycle
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        load;
    logic [7:0]  period_in;
    logic [7:0]  prescale_in;
    logic        mode_in;
    logic [31:0] duty_in;
    logic [3:0]  pwm_out;
    logic        period_tick;
    logic        load_ack;

    int errors = 0;
    int checks = 0;
    int m_per;
    int m_hi[4];
    int m_ack;
    int m_at_tick;
    vec_t vecs[7];

    pwm_multi #(.WIDTH(8), .CHANNELS(4), .PRE_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .load        (load),
        .period_in   (period_in),
        .prescale_in (prescale_in),
        .mode_in     (mode_in),
        .duty_in     (duty_in),
        .pwm_out     (pwm_out),
        .period_tick (period_tick),
        .load_ack    (load_ack)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(int p, int d, int mode, logic [31:0] duty,
                                int per, logic [63:0] hi, int at_tick);
        vec_t v;
        v.p = p[7:0]; v.d = d[7:0]; v.mode = mode[0]; v.duty = duty;
        v.per = per[15:0]; v.hi = hi; v.at_tick = at_tick[0];
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Wait (bounded) for load_ack at a falling edge.
    task automatic wait_ack(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (load_ack) ok = 1'b1;
        end
    endtask

    // Entered at the falling edge of a period_tick cycle; measures up to the
    // next period_tick, optionally pulsing load with a new ch1 duty at two
    // window indices.
    task automatic measure(input int li1, input int d1, input int li2, input int d2);
        int  idx;
        bit  done;
        m_per = 0; m_ack = 0; idx = 0; done = 1'b0;
        for (int c = 0; c < 4; c++) m_hi[c] = 0;
        m_at_tick = int'(pwm_out[1]);
        while (!done) begin
            for (int c = 0; c < 4; c++) if (pwm_out[c]) m_hi[c]++;
            if (idx > 0 && load_ack) m_ack++;
            if (idx == li1) begin
                duty_in[15:8] = d1[7:0]; load = 1'b1;
            end else if (idx == li2) begin
                duty_in[15:8] = d2[7:0]; load = 1'b1;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
            idx++;
            if (period_tick) begin
                done = 1'b1;
            end else if (idx >= 3000) begin
                checks++; errors++;
                $display("FAIL window_timeout: got no period_tick, expected one within 3000 clocks");
                done = 1'b1;
            end
        end
        load = 1'b0;
        m_per = idx;
    endtask

    initial begin
        bit ok;
        int cyc, hi1, ticks, acks, anyhi;

        vecs[0] = mk(9,   0, 0, {8'd255, 8'd10, 8'd3,   8'd0},   10,  {16'd10, 16'd10, 16'd3,   16'd0},   0);
        vecs[1] = mk(3,   2, 0, {8'd0,   8'd4,  8'd2,   8'd1},   12,  {16'd0,  16'd12, 16'd6,   16'd3},   0);
        vecs[2] = mk(4,   0, 1, {8'd0,   8'd5,  8'd2,   8'd1},   8,   {16'd0,  16'd8,  16'd3,   16'd1},   1);
        vecs[3] = mk(4,   1, 1, {8'd255, 8'd0,  8'd4,   8'd3},   16,  {16'd16, 16'd0,  16'd14,  16'd10},  1);
        vecs[4] = mk(1,   0, 1, {8'd1,   8'd0,  8'd2,   8'd1},   2,   {16'd1,  16'd0,  16'd2,   16'd1},   1);
        vecs[5] = mk(0,   3, 0, {8'd0,   8'd1,  8'd0,   8'd1},   4,   {16'd0,  16'd4,  16'd0,   16'd4},   0);
        vecs[6] = mk(255, 0, 0, {8'd1,   8'd0,  8'd255, 8'd128}, 256, {16'd1,  16'd0,  16'd255, 16'd128}, 0);

        rst = 1'b1; en = 1'b1; load = 1'b0;
        period_in = '0; prescale_in = '0; mode_in = 1'b0; duty_in = '0;

        // Reset: outputs must read 0 for every reset cycle.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("reset_out_%0d", i), int'({pwm_out, period_tick, load_ack}), 0);
        end
        rst = 1'b0;

        // Configuration table.
        for (int r = 0; r < 7; r++) begin
            period_in = vecs[r].p; prescale_in = vecs[r].d;
            mode_in = vecs[r].mode; duty_in = vecs[r].duty;
            load = 1'b1;
            @(negedge clk);
            load = 1'b0;
            wait_ack(ok);
            check($sformatf("row%0d_ack_seen", r), int'(ok), 1);
            check($sformatf("row%0d_tick_with_ack", r), int'(period_tick), 1);
            measure(-1, 0, -1, 0);   // first window still carries the old last count
            measure(-1, 0, -1, 0);
            check($sformatf("row%0d_period", r), m_per, int'(vecs[r].per));
            for (int c = 0; c < 4; c++)
                check($sformatf("row%0d_high_ch%0d", r, c), m_hi[c], int'(vecs[r].hi[c*16 +: 16]));
            check($sformatf("row%0d_ch1_at_tick", r), m_at_tick, int'(vecs[r].at_tick));
        end

        // Double buffering at P=9, D=0, edge mode, duty1=3.
        period_in = 8'd9; prescale_in = 8'd0; mode_in = 1'b0;
        duty_in = {8'd255, 8'd10, 8'd3, 8'd0};
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_ack(ok);
        check("db_initial_ack", int'(ok), 1);
        measure(-1, 0, -1, 0);
        measure(2, 7, -1, 0);                 // mid-period load of duty1=7
        check("db_current_high", m_hi[1], 3);
        check("db_no_early_ack", m_ack, 0);
        check("db_ack_at_tick", int'(load_ack), 1);
        measure(2, 4, 5, 6);                  // two loads, the later one wins
        check("db_next_high", m_hi[1], 7);
        check("db_ack_second", int'(load_ack), 1);
        measure(-1, 0, -1, 0);
        check("db_last_load_wins", m_hi[1], 6);
        check("db_no_stray_ack", int'(load_ack), 0);

        // Coincident load and boundary: duty1=2 pending, then duty1=8 loaded
        // in the boundary cycle (window index 9 holds cnt=P).
        measure(3, 2, 9, 8);
        check("co_current_high", m_hi[1], 6);
        check("co_first_ack", int'(load_ack), 1);
        measure(-1, 0, -1, 0);
        check("co_old_shadow_high", m_hi[1], 2);
        check("co_no_mid_ack", m_ack, 0);
        check("co_second_ack", int'(load_ack), 1);
        measure(-1, 0, -1, 0);
        check("co_new_shadow_high", m_hi[1], 8);
        check("co_no_third_ack", int'(load_ack), 0);

        // Enable: freeze at cnt=2 for 7 cycles, then resume.
        @(negedge clk);
        @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check($sformatf("dis_out_%0d", i), int'({pwm_out, period_tick}), 0);
        end
        en = 1'b1;
        @(negedge clk);
        check("en_resume_ch1", int'(pwm_out[1]), 1);
        cyc = 1; hi1 = int'(pwm_out[1]);
        while (!period_tick && cyc < 100) begin
            @(negedge clk);
            cyc++;
            hi1 += int'(pwm_out[1]);
        end
        check("en_cycles_to_tick", cyc, 8);
        check("en_resume_high", hi1, 6);

        // Reset mid-period with a load pending.
        @(negedge clk);
        duty_in[15:8] = 8'd1; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_out_0", int'({pwm_out, period_tick, load_ack}), 0);
        @(negedge clk);
        check("rst_mid_out_1", int'({pwm_out, period_tick, load_ack}), 0);
        rst = 1'b0;
        ticks = 0; acks = 0; anyhi = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            ticks += int'(period_tick);
            acks  += int'(load_ack);
            anyhi += int'(pwm_out != 4'd0);
        end
        check("rst_pending_dropped", acks, 0);
        check("rst_outputs_low", anyhi, 0);
        check("rst_p0_tick_every_clock", ticks, 30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
